// File: rtl/tinyalu_cmd_issuer_if.sv
// Signal bundle between the command issuer, its command producer, the TinyALU and the response consumer.
// cmd and rsp are valid/ready: a transfer happens on a rising edge where valid && ready; valid stays up and the payload stays stable until then.
interface tinyalu_cmd_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic        alu_start;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
    output cmd_ready, alu_start, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_op, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
    input  cmd_ready, alu_start, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_op, rsp_err
  );
endinterface

// File: rtl/tinyalu_cmd_issuer.sv
// TinyALU front-end: buffers commands in a FIFO, issues them one at a time over start/done
// and returns each result (or an error for illegal opcodes / timeouts) on a valid/ready port.
module tinyalu_cmd_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  tinyalu_cmd_issuer_if.master bus,
  output logic                 busy,
  output logic [7:0]           err_count,
  output logic [1:0]           state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;

  state_t state, state_n;

  logic [18:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [7:0]  head_a, head_b;
  logic [2:0]  head_op;

  logic          alu_start, alu_start_n;
  logic [7:0]    alu_a, alu_a_n, alu_b, alu_b_n;
  logic [2:0]    alu_op, alu_op_n;
  logic          rsp_valid, rsp_valid_n, rsp_err, rsp_err_n;
  logic [15:0]   rsp_result, rsp_result_n;
  logic [2:0]    rsp_op, rsp_op_n;
  logic [CW-1:0] tcnt, tcnt_n;
  logic [7:0]    err_count_n;
  logic          err_inc;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.cmd_valid && !full;
  assign pop   = (state == S_IDLE) && !empty;
  assign {head_a, head_b, head_op} = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_comb begin
    state_n      = state;
    alu_start_n  = alu_start;
    alu_a_n      = alu_a;
    alu_b_n      = alu_b;
    alu_op_n     = alu_op;
    rsp_valid_n  = rsp_valid;
    rsp_result_n = rsp_result;
    rsp_op_n     = rsp_op;
    rsp_err_n    = rsp_err;
    tcnt_n       = tcnt;
    err_inc      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          case (head_op)
            3'b000: ;
            3'b001, 3'b010, 3'b011, 3'b100: begin
              alu_a_n     = head_a;
              alu_b_n     = head_b;
              alu_op_n    = head_op;
              alu_start_n = 1'b1;
              tcnt_n      = '0;
              state_n     = S_ISSUE;
            end
            default: begin
              rsp_result_n = 16'h0000;
              rsp_op_n     = head_op;
              rsp_err_n    = 1'b1;
              rsp_valid_n  = 1'b1;
              err_inc      = 1'b1;
              state_n      = S_RESP;
            end
          endcase
        end
      end
      S_ISSUE: begin
        // done is checked first so a completion on the timeout cycle is not an error.
        if (bus.alu_done) begin
          rsp_result_n = bus.alu_result;
          rsp_op_n     = alu_op;
          rsp_err_n    = 1'b0;
          rsp_valid_n  = 1'b1;
          alu_start_n  = 1'b0;
          state_n      = S_RESP;
        end else if (tcnt == TC_LAST) begin
          rsp_result_n = 16'hFFFF;
          rsp_op_n     = alu_op;
          rsp_err_n    = 1'b1;
          rsp_valid_n  = 1'b1;
          alu_start_n  = 1'b0;
          err_inc      = 1'b1;
          state_n      = S_RESP;
        end else begin
          tcnt_n = tcnt + CW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    err_count_n = (err_inc && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      alu_start  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
      tcnt       <= '0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      alu_start  <= alu_start_n;
      alu_a      <= alu_a_n;
      alu_b      <= alu_b_n;
      alu_op     <= alu_op_n;
      rsp_valid  <= rsp_valid_n;
      rsp_result <= rsp_result_n;
      rsp_op     <= rsp_op_n;
      rsp_err    <= rsp_err_n;
      tcnt       <= tcnt_n;
      err_count  <= err_count_n;
    end
  end

  assign bus.cmd_ready  = !full;
  assign bus.alu_start  = alu_start;
  assign bus.alu_a      = alu_a;
  assign bus.alu_b      = alu_b;
  assign bus.alu_op     = alu_op;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_op     = rsp_op;
  assign bus.rsp_err    = rsp_err;
  assign busy           = (state != S_IDLE) || !empty;
  assign state_dbg      = state;
endmodule
